// File: rtl/sdram_axi_burst_reader_pkg.sv
// Shared types and constants for the SDRAM AXI burst reader.
// AXI encodings and the reader FSM state enum.
package sdram_axi_burst_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/sdram_axi_burst_reader_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Head reads as zero while empty so the output is clean after reset.
module sdram_axi_burst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (pop_i) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid_o = (r_count != '0);
    assign head_o  = valid_o ? r_mem[r_rptr] : '0;
    assign count_o = r_count;

endmodule

// File: rtl/sdram_axi_burst_reader.sv
// AXI4 read master streaming a linear SDRAM region into a FIFO via INCR bursts.
// One burst in flight; AR issued only once the FIFO can hold the whole burst.
module sdram_axi_burst_reader
    import sdram_axi_burst_reader_pkg::*;
#(
    parameter int         BURST_LEN  = 16,
    parameter int         FIFO_DEPTH = 64,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [23:0] words_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        outport_rready_o,
    output logic        data_valid_o,
    output logic [31:0] data_o,
    input  logic        data_ready_i
);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state;
    logic [31:0]     r_addr;
    logic [23:0]     r_remaining;
    logic [BW-1:0]   r_beats;
    logic [BW-1:0]   r_beat_cnt;
    logic [7:0]      r_arlen;
    logic            r_arvalid;
    logic            r_rready;
    logic            r_done;
    logic            r_error;

    logic [BW-1:0]   w_beats;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_free;
    logic            w_rfire;
    logic            w_last;
    logic            w_bad;
    logic            w_pop;

    always_comb begin
        w_beats = r_remaining[BW-1:0];
        if (r_remaining >= 24'(BURST_LEN)) begin
            w_beats = BW'(BURST_LEN);
        end
    end

    assign w_free  = CW'(FIFO_DEPTH) - w_count;
    assign w_rfire = outport_rvalid_i & r_rready;
    assign w_last  = (r_beat_cnt == r_beats - BW'(1));
    assign w_bad   = (outport_rresp_i != AXI_RESP_OKAY)
                   | (outport_rid_i != AXI_ID)
                   | (outport_rlast_i != w_last);
    assign w_pop   = data_valid_o & data_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_beat_cnt  <= '0;
            r_arlen     <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i && words_i != '0) begin
                        r_addr      <= base_addr_i;
                        r_remaining <= words_i;
                        r_error     <= 1'b0;
                        r_state     <= ST_WAIT;
                    end else if (start_i) begin
                        r_done <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_free >= CW'(w_beats)) begin
                        r_beats   <= w_beats;
                        r_arlen   <= 8'(w_beats) - 8'd1;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (outport_arready_i) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_rfire) begin
                        if (w_bad) begin
                            r_error <= 1'b1;
                        end
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                        if (w_last) begin
                            r_rready    <= 1'b0;
                            r_addr      <= r_addr + (32'(r_beats) << 2);
                            r_remaining <= r_remaining - 24'(r_beats);
                            if (r_remaining == 24'(r_beats)) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Space was reserved before the AR, so pushes never overflow.
    sdram_axi_burst_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_rfire),
        .push_data_i (outport_rdata_i),
        .pop_i       (w_pop),
        .head_o      (data_o),
        .valid_o     (data_valid_o),
        .count_o     (w_count)
    );

    assign busy_o            = (r_state != ST_IDLE);
    assign done_o            = r_done;
    assign error_o           = r_error;
    assign outport_arvalid_o = r_arvalid;
    assign outport_araddr_o  = r_arvalid ? r_addr : 32'd0;
    assign outport_arid_o    = AXI_ID;
    assign outport_arlen_o   = r_arlen;
    assign outport_arburst_o = AXI_BURST_INCR;
    assign outport_rready_o  = r_rready;

endmodule

// File: tb/tb_sdram_axi_burst_reader.sv
// Directed bench for sdram_axi_burst_reader: bursts, back-pressure, errors, reset.
module tb_sdram_axi_burst_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [23:0] words;
    logic        busy;
    logic        done;
    logic        error;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rready;
    logic        dvalid;
    logic [31:0] dout;
    logic        dready;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_base;
    int gi = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    sdram_axi_burst_reader dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .base_addr_i       (base_addr),
        .words_i           (words),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (error),
        .outport_arvalid_o (arvalid),
        .outport_araddr_o  (araddr),
        .outport_arid_o    (arid),
        .outport_arlen_o   (arlen),
        .outport_arburst_o (arburst),
        .outport_arready_i (arready),
        .outport_rvalid_i  (rvalid),
        .outport_rdata_i   (rdata),
        .outport_rresp_i   (rresp),
        .outport_rid_i     (rid),
        .outport_rlast_i   (rlast),
        .outport_rready_o  (rready),
        .data_valid_o      (dvalid),
        .data_o            (dout),
        .data_ready_i      (dready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (dvalid && dready) got_q.push_back(dout);
        if (done) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [23:0] n);
        base_addr = b;
        words     = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len);
        int g = 0;
        while (!arvalid && g < 200) begin
            step();
            g++;
        end
        chk("ar_seen", {31'd0, arvalid}, 32'd1);
        chk("ar_addr", araddr, a);
        chk("ar_len", {24'd0, arlen}, {24'd0, len});
        chk("ar_id", {28'd0, arid}, 32'd0);
        chk("ar_burst", {30'd0, arburst}, 32'd1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("ar_drop", {31'd0, arvalid}, 32'd0);
    endtask

    task automatic do_r(input logic [31:0] a, input int n,
                        input int bad, input int early);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            rvalid = 1'b1;
            rdata  = memf(a + 32'(i * 4));
            rresp  = (i == bad) ? 2'b10 : 2'b00;
            rid    = 4'd0;
            rlast  = (i == n - 1) || (i == early);
            while (!rready && g < 200) begin
                step();
                g++;
            end
            if (!rready) chk("r_ready_timeout", 32'd0, 32'd1);
            exp_q.push_back(memf(a + 32'(i * 4)));
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic check_drain(input int n);
        int g = 0;
        while (got_q.size() < gi + n && g < 400) begin
            step();
            g++;
        end
        if (got_q.size() < gi + n) begin
            chk("drain_count", 32'(got_q.size() - gi), 32'(n));
        end else begin
            for (int k = 0; k < n; k++) begin
                chk("data_word", got_q[gi], exp_q.pop_front());
                gi++;
            end
        end
    endtask

    initial begin
        logic seen_ar;
        rst = 1'b1; start = 1'b0; base_addr = '0; words = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        rid = '0; rlast = 1'b0; dready = 1'b0;
        repeat (3) step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("rst_arburst", {30'd0, arburst}, 32'd1);
        rst = 1'b0;
        step();

        // two full bursts, consumer always ready
        dready = 1'b1;
        done_base = done_cnt;
        start_xfer(32'h1000, 24'd32);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_lat1", {31'd0, arvalid}, 32'd0);
        step();
        chk("t1_lat2", {31'd0, arvalid}, 32'd1);
        do_ar(32'h1000, 8'd15);
        do_r(32'h1000, 16, -1, -1);
        do_ar(32'h1040, 8'd15);
        do_r(32'h1040, 16, -1, -1);
        check_drain(32);
        step();
        chk("t1_done_cnt", 32'(done_cnt - done_base), 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_err", {31'd0, error}, 32'd0);

        // partial tail burst
        done_base = done_cnt;
        start_xfer(32'h1000, 24'd20);
        do_ar(32'h1000, 8'd15);
        do_r(32'h1000, 16, -1, -1);
        do_ar(32'h1040, 8'd3);
        chk("t2_no_done", 32'(done_cnt - done_base), 32'd0);
        do_r(32'h1040, 4, -1, -1);
        chk("t2_done_pulse", {31'd0, done}, 32'd1);
        check_drain(20);
        chk("t2_done_cnt", 32'(done_cnt - done_base), 32'd1);

        // consumer stalled: fifth AR must wait for 16 pops
        dready = 1'b0;
        done_base = done_cnt;
        start_xfer(32'h4000, 24'd80);
        for (int k = 0; k < 4; k++) begin
            do_ar(32'h4000 + 32'(k * 64), 8'd15);
            do_r(32'h4000 + 32'(k * 64), 16, -1, -1);
        end
        seen_ar = 1'b0;
        repeat (20) begin
            step();
            if (arvalid) seen_ar = 1'b1;
        end
        chk("t3_ar_withheld", {31'd0, seen_ar}, 32'd0);
        dready = 1'b1;
        repeat (15) step();
        chk("t3_ar_15pop", {31'd0, arvalid}, 32'd0);
        step();
        dready = 1'b0;
        chk("t3_ar_16pop", {31'd0, arvalid}, 32'd0);
        step();
        chk("t3_ar_release", {31'd0, arvalid}, 32'd1);
        do_ar(32'h4100, 8'd15);
        do_r(32'h4100, 16, -1, -1);
        dready = 1'b1;
        check_drain(80);
        chk("t3_done_cnt", 32'(done_cnt - done_base), 32'd1);

        // bad RRESP on beat 5
        start_xfer(32'h5000, 24'd16);
        do_ar(32'h5000, 8'd15);
        do_r(32'h5000, 16, 4, -1);
        check_drain(16);
        chk("t4_err", {31'd0, error}, 32'd1);
        repeat (5) step();
        chk("t4_err_sticky", {31'd0, error}, 32'd1);

        // early RLAST on beat 8, then zero-length start
        start_xfer(32'h6000, 24'd16);
        chk("t5_err_clr", {31'd0, error}, 32'd0);
        do_ar(32'h6000, 8'd15);
        do_r(32'h6000, 16, -1, 7);
        check_drain(16);
        chk("t5_err", {31'd0, error}, 32'd1);
        done_base = done_cnt;
        start_xfer(32'h7000, 24'd0);
        chk("t5_zero_done", {31'd0, done}, 32'd1);
        chk("t5_zero_busy", {31'd0, busy}, 32'd0);
        chk("t5_zero_ar", {31'd0, arvalid}, 32'd0);
        step();
        chk("t5_zero_done_end", {31'd0, done}, 32'd0);
        chk("t5_zero_ar2", {31'd0, arvalid}, 32'd0);
        chk("t5_zero_cnt", 32'(done_cnt - done_base), 32'd1);

        // reset mid-burst
        dready = 1'b0;
        start_xfer(32'h7000, 24'd32);
        do_ar(32'h7000, 8'd15);
        do_r(32'h7000, 5, -1, -1);
        chk("t6_in_data", {31'd0, rready}, 32'd1);
        rst = 1'b1;
        step();
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_err", {31'd0, error}, 32'd0);
        chk("t6_rready", {31'd0, rready}, 32'd0);
        chk("t6_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t6_araddr", araddr, 32'd0);
        chk("t6_arlen", {24'd0, arlen}, 32'd0);
        chk("t6_dvalid", {31'd0, dvalid}, 32'd0);
        chk("t6_dout", dout, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        step();
        dready = 1'b1;
        done_base = done_cnt;
        start_xfer(32'h8000, 24'd16);
        do_ar(32'h8000, 8'd15);
        do_r(32'h8000, 16, -1, -1);
        check_drain(16);
        chk("t6_done_cnt", 32'(done_cnt - done_base), 32'd1);
        chk("t6_err_after", {31'd0, error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
